// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared state encoding and defaults for the MEM-stage access controller
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          TIMEOUT_CYC_DEF = 16;
  localparam logic [31:0] ERR_DATA_DEF    = 32'hDEADBEEF;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - pipeline-side and memory-side signals of the MEM-stage access controller
interface mem_access_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              MemRead_i;
  logic              MemWrite_i;
  logic [ADDR_W-1:0] Addr_i;
  logic [DATA_W-1:0] WriteData_i;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic [DATA_W-1:0] ReadMem_o;
  logic              stall_o;
  logic              err_o;

  modport master (
    input  MemRead_i, MemWrite_i, Addr_i, WriteData_i, mem_ack_i, mem_rdata_i,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, ReadMem_o, stall_o, err_o
  );

  modport slave (
    output MemRead_i, MemWrite_i, Addr_i, WriteData_i, mem_ack_i, mem_rdata_i,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, ReadMem_o, stall_o, err_o
  );
endinterface

// File: rtl/mem_access_ctrl_timeout_cnt.sv
// rtl/mem_access_ctrl_timeout_cnt.sv - BUSY-cycle counter with terminal-count flag for the access timeout
module mem_timeout_cnt #(
  parameter int MAX = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  assign tc = (count == 8'(MAX - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage req/ack data-memory controller; MEM_LAST_READ_BUF_EN adds a last-read buffer
module mem_access_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter logic [DATA_W-1:0] ERR_DATA    = DATA_W'(ERR_DATA_DEF)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mem_access_ctrl_if.master bus
);

  state_t state;
  logic   access;
  logic   is_read;
  logic   is_write;
  logic   cnt_tc;

  assign access   = bus.MemRead_i | bus.MemWrite_i;
  assign is_write = bus.MemWrite_i;
  assign is_read  = bus.MemRead_i & ~bus.MemWrite_i;

  assign bus.stall_o = ((state == IDLE) & access) | (state == BUSY);

  mem_timeout_cnt #(
    .MAX(TIMEOUT_CYC)
  ) u_timeout (
    .clk(clk_i),
    .rst(rst_i),
    .clr(state == IDLE),
    .en ((state == BUSY) & ~bus.mem_ack_i),
    .tc (cnt_tc)
  );

`ifdef MEM_LAST_READ_BUF_EN
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic              buf_hit;

  assign buf_hit = is_read & buf_valid & (buf_addr == bus.Addr_i);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= IDLE;
      bus.mem_req_o   <= 1'b0;
      bus.mem_we_o    <= 1'b0;
      bus.mem_addr_o  <= '0;
      bus.mem_wdata_o <= '0;
      bus.ReadMem_o   <= '0;
      bus.err_o       <= 1'b0;
`ifdef MEM_LAST_READ_BUF_EN
      buf_valid       <= 1'b0;
      buf_addr        <= '0;
      buf_data        <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (access) begin
`ifdef MEM_LAST_READ_BUF_EN
            if (is_write) buf_valid <= 1'b0;
`endif
            if (!word_aligned(bus.Addr_i[1:0])) begin
              bus.err_o <= 1'b1;
              if (is_read) bus.ReadMem_o <= ERR_DATA;
              state <= DONE;
`ifdef MEM_LAST_READ_BUF_EN
            end else if (buf_hit) begin
              bus.ReadMem_o <= buf_data;
              state         <= DONE;
`endif
            end else begin
              bus.mem_req_o   <= 1'b1;
              bus.mem_we_o    <= is_write;
              bus.mem_addr_o  <= bus.Addr_i[ADDR_W-1:0];
              bus.mem_wdata_o <= bus.WriteData_i;
              state           <= BUSY;
            end
          end
        end

        BUSY: begin
          // ack is checked first so a reply in the terminal cycle is not an error
          if (bus.mem_ack_i) begin
            bus.mem_req_o <= 1'b0;
            bus.mem_we_o  <= 1'b0;
            if (!bus.mem_we_o) begin
              bus.ReadMem_o <= bus.mem_rdata_i;
`ifdef MEM_LAST_READ_BUF_EN
              buf_valid <= 1'b1;
              buf_addr  <= bus.mem_addr_o;
              buf_data  <= bus.mem_rdata_i;
`endif
            end
            state <= DONE;
          end else if (cnt_tc) begin
            bus.mem_req_o <= 1'b0;
            bus.mem_we_o  <= 1'b0;
            bus.err_o     <= 1'b1;
            if (!bus.mem_we_o) bus.ReadMem_o <= ERR_DATA;
            state <= DONE;
          end
        end

        // inputs still belong to the finished instruction here
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
